key_matrix_stream: RTL

- Sits directly downstream of key expansion in the chaos image-cipher parameter path.
- Loads the two chaotic key vectors M (DIM entries) and N (DIM entries) serially and holds them in local RAM.
- Streams the DIM x DIM key matrix K[i][j] in row-major order, one byte per beat, to the pixel diffusion/XOR stage, with valid/ready backpressure.
- One key byte is produced per accepted beat.

---
 rtl/key_stream_pkg.sv | 24 ++
 rtl/km_vec_ram.sv | 27 ++
 rtl/key_matrix_stream.sv | 139 +++++++++++++
 3 files changed

// File: rtl/key_stream_pkg.sv
// Shared types and helpers for the key-matrix streaming block.
package key_stream_pkg;

  localparam int KM_DIM   = 256;
  localparam int KM_IDX_W = $clog2(KM_DIM);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_M,
    ST_LOAD_N,
    ST_GEN,
    ST_FLUSH
  } km_state_e;

  // Extract a width-bit field starting at bit lsb of a (zero-extended) product.
  function automatic logic [127:0] field_extract(input logic [127:0] word,
                                                 input int lsb,
                                                 input int width);
    logic [127:0] mask;
    mask = (128'(1) << width) - 128'(1);
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/km_vec_ram.sv
// Simple dual-port vector RAM: one write port, one synchronous read port with read enable.
module km_vec_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data holds when re is low so a stalled pipeline keeps its operands.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/key_matrix_stream.sv
// Loads chaotic key vectors M and N, then streams K[i][j] = field(M[i]*N[j]) row-major.
module key_matrix_stream
  import key_stream_pkg::*;
#(
  parameter int DIM     = 256,
  parameter int DATA_W  = 32,
  parameter int KEY_W   = 8,
  parameter int KEY_LSB = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEY_W-1:0]  out_key,
  output logic              out_last_row,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(DIM);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIM - 1);

  km_state_e         state;
  logic [IDX_W-1:0]  ld_cnt;
  logic [IDX_W-1:0]  gi, gj;
  logic              done_r;
  logic              advance, issue;
  logic              we_m, we_n;
  logic [DATA_W-1:0] m_q, n_q;
  logic [2*DATA_W-1:0] prod;

  logic              vld_p1, last_row_p1, last_p1;
  logic              vld_p2, last_row_p2, last_p2;
  logic [KEY_W-1:0]  key_p2;

  assign ld_ready = (state == ST_LOAD_M) || (state == ST_LOAD_N);
  assign busy     = (state != ST_IDLE);
  assign done     = done_r;
  assign we_m     = (state == ST_LOAD_M) && ld_valid;
  assign we_n     = (state == ST_LOAD_N) && ld_valid;
  assign advance  = !vld_p2 || out_ready;
  assign issue    = advance && (state == ST_GEN);
  assign prod     = {{DATA_W{1'b0}}, m_q} * {{DATA_W{1'b0}}, n_q};

  km_vec_ram #(.DEPTH(DIM), .DATA_W(DATA_W), .ADDR_W(IDX_W)) u_m_ram (
    .clk(clk), .we(we_m), .waddr(ld_cnt), .wdata(ld_data),
    .re(issue), .raddr(gi), .rdata(m_q)
  );

  km_vec_ram #(.DEPTH(DIM), .DATA_W(DATA_W), .ADDR_W(IDX_W)) u_n_ram (
    .clk(clk), .we(we_n), .waddr(ld_cnt), .wdata(ld_data),
    .re(issue), .raddr(gj), .rdata(n_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ld_cnt <= '0;
      gi     <= '0;
      gj     <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_LOAD_M;
            ld_cnt <= '0;
          end
        end
        ST_LOAD_M: begin
          if (ld_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == IDX_MAX) state <= ST_LOAD_N;
          end
        end
        ST_LOAD_N: begin
          if (ld_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == IDX_MAX) begin
              state <= ST_GEN;
              gi    <= '0;
              gj    <= '0;
            end
          end
        end
        ST_GEN: begin
          if (issue) begin
            gj <= gj + 1'b1;
            if (gj == IDX_MAX) begin
              gi <= gi + 1'b1;
              if (gi == IDX_MAX) state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (vld_p2 && out_ready && last_p2) begin
            done_r <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      last_row_p1 <= 1'b0;
      last_p1     <= 1'b0;
      vld_p2      <= 1'b0;
      last_row_p2 <= 1'b0;
      last_p2     <= 1'b0;
      key_p2      <= '0;
    end else if (advance) begin
      // p1: RAM read issued, operand flags tracked alongside
      vld_p1      <= issue;
      last_row_p1 <= issue && (gj == IDX_MAX);
      last_p1     <= issue && (gj == IDX_MAX) && (gi == IDX_MAX);
      // p2: multiply and key-field extraction
      vld_p2      <= vld_p1;
      last_row_p2 <= last_row_p1;
      last_p2     <= last_p1;
      key_p2      <= vld_p1 ? KEY_W'(field_extract(128'(prod), KEY_LSB, KEY_W)) : '0;
    end
  end

  assign out_valid    = vld_p2;
  assign out_key      = key_p2;
  assign out_last_row = last_row_p2;
  assign out_last     = last_p2;

endmodule
